// File: rtl/note_detector.sv
// Tone-period note detector: measures rising-edge to rising-edge intervals of a
// square-wave input and classifies them into one of seven scale notes with debouncing.
module note_detector #(
    parameter int          CNT_W       = 20,
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter int unsigned TOL_CYC     = 4000,
    parameter int unsigned STABLE_N    = 2,
    parameter int unsigned P_DO        = 382263,
    parameter int unsigned P_RE        = 340599,
    parameter int unsigned P_MI        = 303398,
    parameter int unsigned P_FA        = 286368,
    parameter int unsigned P_SOL       = 255102,
    parameter int unsigned P_LA        = 227272,
    parameter int unsigned P_SI        = 202511
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tone_in,
    output logic [2:0]       note_idx,
    output logic             note_valid,
    output logic             note_strobe,
    output logic [CNT_W-1:0] period,
    output logic             no_signal
);

    typedef enum logic {
        S_IDLE,
        S_MEASURE
    } state_t;

    localparam logic [2:0]       NOTE_NONE = 3'd7;
    localparam logic [2:0]       STABLE_V  = 3'(STABLE_N);
    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // Index 0 is do, index 6 is si.
    localparam logic [6:0][31:0] NOMINAL = {P_SI, P_LA, P_SOL, P_FA, P_MI, P_RE, P_DO};

    // Input conditioning
    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;
    logic tone_edge_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg     <= 1'b0;
            sync2_reg     <= 1'b0;
            prev_reg      <= 1'b0;
            tone_edge_reg <= 1'b0;
        end else begin
            sync1_reg     <= tone_in;
            sync2_reg     <= sync1_reg;
            prev_reg      <= sync2_reg;
            tone_edge_reg <= sync2_reg & ~prev_reg;
        end
    end

    // Measurement and decision state
    state_t           state_reg,  state_next;
    logic [CNT_W-1:0] cnt_reg,    cnt_next;
    logic [2:0]       cand_reg,   cand_next;
    logic [2:0]       match_reg,  match_next;
    logic [2:0]       note_reg,   note_next;
    logic             valid_reg,  valid_next;
    logic             strobe_reg, strobe_next;
    logic [CNT_W-1:0] period_reg, period_next;
    logic             nosig_reg,  nosig_next;

    // Per-note window match on the current count; windows are inclusive and
    // the lower bound clamps at zero so a small nominal cannot wrap.
    logic [6:0] class_hit;

    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_window
            localparam logic [CNT_W:0] WIN_LO = (NOMINAL[gi] > TOL_CYC) ?
                                                (CNT_W+1)'(NOMINAL[gi] - TOL_CYC) : '0;
            localparam logic [CNT_W:0] WIN_HI = (CNT_W+1)'(NOMINAL[gi] + TOL_CYC);
            assign class_hit[gi] = ({1'b0, cnt_reg} >= WIN_LO) &&
                                   ({1'b0, cnt_reg} <= WIN_HI);
        end
    endgenerate

    logic [2:0] class_idx;

    always_comb begin
        class_idx = NOTE_NONE;
        for (int k = 0; k < 7; k++) begin
            if (class_hit[k]) begin
                class_idx = 3'(k);
            end
        end
    end

    logic [2:0] cand_upd;
    logic [2:0] match_upd;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        cand_next   = cand_reg;
        match_next  = match_reg;
        note_next   = note_reg;
        valid_next  = valid_reg;
        strobe_next = 1'b0;
        period_next = period_reg;
        nosig_next  = nosig_reg;
        cand_upd    = cand_reg;
        match_upd   = match_reg;

        case (state_reg)
            S_IDLE: begin
                // First edge only opens a period; nothing to classify yet.
                if (tone_edge_reg) begin
                    cnt_next   = CNT_ONE;
                    state_next = S_MEASURE;
                end
            end

            S_MEASURE: begin
                if (tone_edge_reg) begin
                    period_next = cnt_reg;
                    cnt_next    = CNT_ONE;
                    nosig_next  = 1'b0;
                    if (class_idx == NOTE_NONE) begin
                        note_next  = NOTE_NONE;
                        valid_next = 1'b0;
                        cand_next  = NOTE_NONE;
                        match_next = 3'd0;
                    end else begin
                        if (class_idx == cand_reg) begin
                            cand_upd  = cand_reg;
                            match_upd = (match_reg >= STABLE_V) ? STABLE_V : match_reg + 3'd1;
                        end else begin
                            cand_upd  = class_idx;
                            match_upd = 3'd1;
                        end
                        cand_next  = cand_upd;
                        match_next = match_upd;
                        // Strobe only when the confirmed note actually changes.
                        if ((match_upd >= STABLE_V) &&
                            (!valid_reg || (note_reg != cand_upd))) begin
                            note_next   = cand_upd;
                            valid_next  = 1'b1;
                            strobe_next = 1'b1;
                        end
                    end
                end else if (cnt_reg == TIMEOUT_V) begin
                    nosig_next = 1'b1;
                    note_next  = NOTE_NONE;
                    valid_next = 1'b0;
                    cand_next  = NOTE_NONE;
                    match_next = 3'd0;
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            cand_reg   <= NOTE_NONE;
            match_reg  <= 3'd0;
            note_reg   <= NOTE_NONE;
            valid_reg  <= 1'b0;
            strobe_reg <= 1'b0;
            period_reg <= '0;
            nosig_reg  <= 1'b1;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            cand_reg   <= cand_next;
            match_reg  <= match_next;
            note_reg   <= note_next;
            valid_reg  <= valid_next;
            strobe_reg <= strobe_next;
            period_reg <= period_next;
            nosig_reg  <= nosig_next;
        end
    end

    assign note_idx    = note_reg;
    assign note_valid  = valid_reg;
    assign note_strobe = strobe_reg;
    assign period      = period_reg;
    assign no_signal   = nosig_reg;

endmodule

// File: tb/tb_note_detector.sv
// Bench for note_detector with scaled-down periods; an event-level model built on
// absolute edge times predicts every output at the cycle the DUT should update it.
module tb_note_detector;

    localparam int CNT_W   = 12;
    localparam int TIMEOUT = 2000;
    localparam int TOL     = 8;
    localparam int STABLE  = 2;
    localparam int LAT     = 4;

    int nom [7] = '{764, 681, 607, 573, 510, 455, 405};

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             tone_in = 1'b0;
    logic [2:0]       note_idx;
    logic             note_valid;
    logic             note_strobe;
    logic [CNT_W-1:0] period;
    logic             no_signal;

    note_detector #(
        .CNT_W      (CNT_W),
        .TIMEOUT_CYC(TIMEOUT),
        .TOL_CYC    (TOL),
        .STABLE_N   (STABLE),
        .P_DO       (764),
        .P_RE       (681),
        .P_MI       (607),
        .P_FA       (573),
        .P_SOL      (510),
        .P_LA       (455),
        .P_SI       (405)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tone_in    (tone_in),
        .note_idx   (note_idx),
        .note_valid (note_valid),
        .note_strobe(note_strobe),
        .period     (period),
        .no_signal  (no_signal)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    string phase    = "init";

    // Reference state: absolute cycle of the last counted edge plus decision state
    bit m_meas;
    int m_last;
    int m_cand, m_match, m_note, m_valid, m_strobe, m_per, m_nosig;
    int edge_q [$];
    bit prev_ev = 1'b0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int classify(input int p);
        for (int k = 0; k < 7; k++) begin
            if (p >= nom[k] - TOL && p <= nom[k] + TOL) return k;
        end
        return 7;
    endfunction

    task automatic model_reset();
        m_meas = 0; m_last = 0; m_cand = 7; m_match = 0;
        m_note = 7; m_valid = 0; m_strobe = 0; m_per = 0; m_nosig = 1;
    endtask

    task automatic model_lose();
        m_note = 7; m_valid = 0; m_cand = 7; m_match = 0;
    endtask

    task automatic model_edge(input int c);
        int p, cls;
        if (!m_meas) begin
            m_meas = 1;
            m_last = c;
            $display("edge cyc=%0d start of period", c);
        end else begin
            p      = c - m_last;
            m_last = c;
            m_per  = p;
            m_nosig = 0;
            cls    = classify(p);
            if (cls == 7) begin
                model_lose();
            end else begin
                if (cls == m_cand) m_match = (m_match + 1 > STABLE) ? STABLE : m_match + 1;
                else begin
                    m_cand  = cls;
                    m_match = 1;
                end
                if (m_match >= STABLE && (!m_valid || m_note != m_cand)) begin
                    m_note = m_cand; m_valid = 1; m_strobe = 1;
                end
            end
            $display("edge cyc=%0d period=%0d class=%0d idx=%0d valid=%0d strobe=%0d",
                     c, p, cls, m_note, m_valid, m_strobe);
        end
    endtask

    task automatic check_all();
        check_eq({phase, ".idx"},    int'(note_idx),    m_note);
        check_eq({phase, ".valid"},  int'(note_valid),  m_valid);
        check_eq({phase, ".strobe"}, int'(note_strobe), m_strobe);
        check_eq({phase, ".period"}, int'(period),      m_per);
        check_eq({phase, ".nosig"},  int'(no_signal),   m_nosig);
    endtask

    task automatic tick();
        bit r, ev;
        r = rst;
        @(posedge clk);
        #1;
        cyc++;
        ev = 0;
        m_strobe = 0;
        if (r) begin
            model_reset();
            edge_q.delete();
            ev = 1;
        end else if (edge_q.size() > 0 && edge_q[0] == cyc) begin
            void'(edge_q.pop_front());
            model_edge(cyc);
            ev = 1;
        end else if (m_meas && (cyc - m_last) == TIMEOUT) begin
            m_meas = 0;
            m_nosig = 1;
            model_lose();
            $display("timeout cyc=%0d", cyc);
            ev = 1;
        end
        if (ev || prev_ev || (m_meas && (cyc - m_last) == TIMEOUT - 1) || (cyc % 64) == 0)
            check_all();
        prev_ev = ev;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // One rising edge now; the next rising edge comes from the next call, p cycles later.
    task automatic tone_period(input int p);
        tone_in = 1'b1;
        edge_q.push_back(cyc + LAT);
        ticks(p / 2);
        tone_in = 1'b0;
        ticks(p - p / 2);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, p, r;
        model_reset();
        phase = "reset";
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        ticks(5);

        phase = "la";
        for (int i = 0; i < 4; i++) tone_period(nom[5]);

        phase = "switch_do";
        for (int i = 0; i < 4; i++) tone_period(nom[0]);

        phase = "tol";
        for (int i = 0; i < 3; i++) tone_period(nom[5] + TOL);
        tone_period(nom[5] + TOL + 1);
        for (int i = 0; i < 3; i++) tone_period(nom[5] - TOL);
        tone_period(nom[5] - TOL - 1);
        tone_period(nom[5]);

        phase = "glitch";
        for (int i = 0; i < 3; i++) tone_period(nom[4]);
        tone_period(200);
        for (int i = 0; i < 3; i++) tone_period(nom[4]);

        phase = "timeout";
        for (int i = 0; i < 3; i++) tone_period(nom[2]);
        ticks(TIMEOUT + 50);
        for (int i = 0; i < 4; i++) tone_period(nom[2]);

        phase = "edge_at_timeout";
        tone_period(TIMEOUT);
        for (int i = 0; i < 3; i++) tone_period(nom[1]);

        phase = "reset_mid";
        for (int i = 0; i < 4; i++) tone_period(nom[6]);
        tone_in = 1'b1;
        edge_q.push_back(cyc + LAT);
        ticks(nom[6] / 2);
        tone_in = 1'b0;
        ticks(60);
        do_reset();
        ticks(20);
        for (int i = 0; i < 4; i++) tone_period(nom[6]);

        phase = "random";
        k = 3;
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 15) k = int'($urandom_range(0, 6));
            if (r < 70) begin
                p = nom[k] + int'($urandom_range(0, 2 * TOL)) - TOL;
            end else if (r < 85) begin
                p = int'($urandom_range(120, 900));
            end else begin
                case ($urandom_range(0, 3))
                    0: p = nom[k] + TOL;
                    1: p = nom[k] - TOL;
                    2: p = nom[k] + TOL + 1;
                    default: p = nom[k] - TOL - 1;
                endcase
            end
            tone_period(p);
        end
        ticks(10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
